// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: voice count, default sample
// width, mixer FSM states and the normalisation-shift helper.
package synth_pkg;

    localparam int unsigned NUM_VOICES       = 8;
    localparam int unsigned SAMPLE_WIDTH_DEF = 16;
    localparam int unsigned VOICE_CNT_WIDTH  = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        NORM,
        OUT
    } mix_state_t;

    // Right-shift used to scale the voice sum by the number of active voices.
    function automatic logic [1:0] norm_shift(input logic [NUM_VOICES-1:0] mask);
        logic [VOICE_CNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            n = n + VOICE_CNT_WIDTH'(mask[i]);
        end
        if (n <= VOICE_CNT_WIDTH'(1)) begin
            norm_shift = 2'd0;
        end else if (n == VOICE_CNT_WIDTH'(2)) begin
            norm_shift = 2'd1;
        end else if (n <= VOICE_CNT_WIDTH'(4)) begin
            norm_shift = 2'd2;
        end else begin
            norm_shift = 2'd3;
        end
    endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// Fixed-depth 1-bit delay line that tracks which wavetable reads return data.
// Ports: clk_in/rst_in (async active-low), d_in strobe in, q_out strobe
// delayed by DEPTH cycles.
module rd_valid_pipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d_in,
    output logic q_out
);

    logic [DEPTH-1:0] sr;

    // Shift in at bit 0; the truncating cast drops the oldest bit.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sr <= '0;
        end else begin
            sr <= DEPTH'({sr, d_in});
        end
    end

    assign q_out = sr[DEPTH-1];

endmodule

// File: rtl/voice_mixer.sv
// Frame-based voice mixer: on each sample tick, snapshots the 8 voice
// addresses and active mask, reads one wavetable sample per active voice,
// sums them and scales the sum by the active-voice count.
// Ports: clk_in, rst_in (async active-low); addr_in/active_voices_in voice
// state; sample_tick_in frame start; rd_addr_out/rd_en_out/rd_data_in
// wavetable read port; mix_out/mix_valid_out result; busy_out frame in
// progress; overrun_out tick received while busy.
module voice_mixer
    import synth_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int unsigned RD_LATENCY   = 2
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0]  addr_in,
    input  logic [NUM_VOICES-1:0]                  active_voices_in,
    input  logic                                   sample_tick_in,
    output logic [ADDR_WIDTH-1:0]                  rd_addr_out,
    output logic                                   rd_en_out,
    input  logic signed [SAMPLE_WIDTH-1:0]         rd_data_in,
    output logic signed [SAMPLE_WIDTH-1:0]         mix_out,
    output logic                                   mix_valid_out,
    output logic                                   busy_out,
    output logic                                   overrun_out
);

    // Three guard bits hold the sum of eight full-scale samples.
    localparam int unsigned ACC_WIDTH = SAMPLE_WIDTH + 3;
    localparam int unsigned CNT_WIDTH = 3;

    mix_state_t                            state;
    logic [CNT_WIDTH-1:0]                  cnt;
    logic [CNT_WIDTH-1:0]                  next_voice_c;
    logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0] snap_addr;
    logic [NUM_VOICES-1:0]                 snap_active;
    logic signed [ACC_WIDTH-1:0]           acc;
    logic                                  rd_valid;

    assign next_voice_c = cnt + CNT_WIDTH'(1);

    // Marks the cycles in which rd_data_in carries a requested sample.
    rd_valid_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_valid_pipe (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (rd_en_out),
        .q_out  (rd_valid)
    );

    // Frame sequencer, read issue, accumulation and output registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            cnt           <= '0;
            snap_addr     <= '0;
            snap_active   <= '0;
            acc           <= '0;
            rd_addr_out   <= '0;
            rd_en_out     <= 1'b0;
            mix_out       <= '0;
            mix_valid_out <= 1'b0;
            busy_out      <= 1'b0;
            overrun_out   <= 1'b0;
        end else begin
            overrun_out   <= sample_tick_in && busy_out;
            mix_valid_out <= 1'b0;

            if (rd_valid) begin
                acc <= acc + ACC_WIDTH'(rd_data_in);
            end

            case (state)
                IDLE: begin
                    if (sample_tick_in) begin
                        snap_addr   <= addr_in;
                        snap_active <= active_voices_in;
                        acc         <= '0;
                        busy_out    <= 1'b1;
                        // Voice 0 is issued straight from the inputs so the
                        // first read lands in the cycle right after the tick.
                        rd_en_out   <= active_voices_in[0];
                        rd_addr_out <= active_voices_in[0] ? addr_in[0] : '0;
                        cnt         <= '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt == CNT_WIDTH'(NUM_VOICES - 1)) begin
                        rd_en_out   <= 1'b0;
                        rd_addr_out <= '0;
                        cnt         <= '0;
                        state       <= DRAIN;
                    end else begin
                        rd_en_out   <= snap_active[next_voice_c];
                        rd_addr_out <= snap_active[next_voice_c] ?
                                       snap_addr[next_voice_c] : '0;
                        cnt         <= next_voice_c;
                    end
                end
                DRAIN: begin
                    if (cnt == CNT_WIDTH'(RD_LATENCY - 1)) begin
                        cnt   <= '0;
                        state <= NORM;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                NORM: begin
                    mix_out       <= SAMPLE_WIDTH'(acc >>> norm_shift(snap_active));
                    mix_valid_out <= 1'b1;
                    state         <= OUT;
                end
                OUT: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer with a 2-cycle-latency wavetable model.
module tb_voice_mixer;

    logic                    clk_in = 1'b0;
    logic                    rst_in = 1'b0;
    logic [7:0][7:0]         addr_in = '0;
    logic [7:0]              active_voices_in = '0;
    logic                    sample_tick_in = 1'b0;
    logic [7:0]              rd_addr_out;
    logic                    rd_en_out;
    logic signed [15:0]      rd_data_in;
    logic signed [15:0]      mix_out;
    logic                    mix_valid_out;
    logic                    busy_out;
    logic                    overrun_out;

    int total  = 0;
    int passed = 0;

    voice_mixer dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .addr_in          (addr_in),
        .active_voices_in (active_voices_in),
        .sample_tick_in   (sample_tick_in),
        .rd_addr_out      (rd_addr_out),
        .rd_en_out        (rd_en_out),
        .rd_data_in       (rd_data_in),
        .mix_out          (mix_out),
        .mix_valid_out    (mix_valid_out),
        .busy_out         (busy_out),
        .overrun_out      (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    // Wavetable model: data for a read appears two cycles after rd_en_out;
    // otherwise the bus carries a junk pattern that must not be summed.
    logic signed [15:0] mem [256];
    logic               p1_en = 1'b0, p2_en = 1'b0;
    logic [7:0]         p1_a = '0, p2_a = '0;

    always @(posedge clk_in) begin
        p1_en <= rd_en_out;
        p1_a  <= rd_addr_out;
        p2_en <= p1_en;
        p2_a  <= p1_a;
    end

    assign rd_data_in = p2_en ? mem[p2_a] : 16'sh4321;

    // Per-cycle observations of one frame; index k is cycles after the tick.
    logic [16:0]        v_en, v_valid, v_busy, v_ovr;
    logic [7:0]         cap_addr [17];
    logic signed [15:0] cap_mix  [17];

    localparam logic [16:0] BUSY_EXP  = 17'h01FFE;
    localparam logic [16:0] VALID_EXP = 17'h01000;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic fill(input logic signed [15:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic run_frame(input int tick2_at, input bit scramble);
        step();
        sample_tick_in = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                step();
                sample_tick_in = (k == tick2_at);
                if (scramble && k == 1) begin
                    addr_in          = {8{8'd200}};
                    active_voices_in = 8'hFF;
                end
            end
            v_en[k]     = rd_en_out;
            v_valid[k]  = mix_valid_out;
            v_busy[k]   = busy_out;
            v_ovr[k]    = overrun_out;
            cap_addr[k] = rd_addr_out;
            cap_mix[k]  = mix_out;
        end
        step();
        sample_tick_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        step();
        step();
        total++; if (rd_en_out !== 1'b0) $display("FAIL reset_rd_en got=%b exp=0", rd_en_out); else passed++;
        total++; if (rd_addr_out !== 8'd0) $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr_out); else passed++;
        total++; if (mix_out !== 16'sd0) $display("FAIL reset_mix got=%0d exp=0", mix_out); else passed++;
        total++; if ({mix_valid_out, busy_out, overrun_out} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {mix_valid_out, busy_out, overrun_out}); else passed++;
        rst_in = 1'b1;
        step();
    endtask

    task automatic test_all_active();
        fill(16'sd1000);
        for (int i = 0; i < 8; i++) addr_in[i] = 8'(i * 10 + 1);
        active_voices_in = 8'hFF;
        run_frame(-1, 1'b0);
        total++; if (v_en !== 17'h001FE) $display("FAIL all_en got=%h exp=001fe", v_en); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (cap_addr[i+1] !== 8'(i * 10 + 1))
                $display("FAIL all_addr%0d got=%0d exp=%0d", i, cap_addr[i+1], i * 10 + 1);
            else passed++;
        end
        total++; if (v_valid !== VALID_EXP) $display("FAIL all_valid got=%h exp=%h", v_valid, VALID_EXP); else passed++;
        total++; if (v_busy !== BUSY_EXP) $display("FAIL all_busy got=%h exp=%h", v_busy, BUSY_EXP); else passed++;
        total++; if (cap_mix[12] !== 16'sd1000) $display("FAIL all_mix got=%0d exp=1000", cap_mix[12]); else passed++;
        total++; if (cap_mix[16] !== 16'sd1000) $display("FAIL all_hold got=%0d exp=1000", cap_mix[16]); else passed++;
        total++; if (v_ovr !== 17'h0) $display("FAIL all_ovr got=%h exp=0", v_ovr); else passed++;
    endtask

    task automatic test_sparse_snapshot();
        fill(16'sh1111);
        mem[3]   = 16'sd32767;
        mem[9]   = 16'sd32767;
        mem[200] = -16'sd5000;
        addr_in  = {8{8'd77}};
        addr_in[0] = 8'd3;
        addr_in[2] = 8'd9;
        active_voices_in = 8'b0000_0101;
        run_frame(-1, 1'b1);
        total++; if (v_en !== 17'h0000A) $display("FAIL sparse_en got=%h exp=0000a", v_en); else passed++;
        total++; if (cap_addr[1] !== 8'd3) $display("FAIL sparse_addr0 got=%0d exp=3", cap_addr[1]); else passed++;
        total++; if (cap_addr[2] !== 8'd0) $display("FAIL sparse_addr1 got=%0d exp=0", cap_addr[2]); else passed++;
        total++; if (cap_addr[3] !== 8'd9) $display("FAIL sparse_addr2 got=%0d exp=9", cap_addr[3]); else passed++;
        total++; if (v_valid !== VALID_EXP) $display("FAIL sparse_valid got=%h exp=%h", v_valid, VALID_EXP); else passed++;
        total++; if (cap_mix[12] !== 16'sd32767) $display("FAIL sparse_mix got=%0d exp=32767", cap_mix[12]); else passed++;
    endtask

    task automatic test_no_voices();
        fill(16'sd500);
        active_voices_in = 8'h00;
        run_frame(-1, 1'b0);
        total++; if (v_en !== 17'h0) $display("FAIL none_en got=%h exp=0", v_en); else passed++;
        total++; if (v_valid !== VALID_EXP) $display("FAIL none_valid got=%h exp=%h", v_valid, VALID_EXP); else passed++;
        total++; if (cap_mix[12] !== 16'sd0) $display("FAIL none_mix got=%0d exp=0", cap_mix[12]); else passed++;
        total++; if (v_busy !== BUSY_EXP) $display("FAIL none_busy got=%h exp=%h", v_busy, BUSY_EXP); else passed++;
    endtask

    task automatic test_full_negative();
        fill(16'sh8000);
        active_voices_in = 8'hFF;
        run_frame(-1, 1'b0);
        total++; if (cap_mix[12] !== 16'sh8000) $display("FAIL neg_mix got=%0d exp=-32768", cap_mix[12]); else passed++;
        total++; if (v_valid !== VALID_EXP) $display("FAIL neg_valid got=%h exp=%h", v_valid, VALID_EXP); else passed++;
    endtask

    task automatic test_scaling();
        // Three voices: 300 + 600 - 151 = 749, >>> 2 -> 187.
        fill(16'sh2222);
        addr_in = '0;
        addr_in[0] = 8'd5; addr_in[1] = 8'd6; addr_in[2] = 8'd7;
        mem[5] = 16'sd300; mem[6] = 16'sd600; mem[7] = -16'sd151;
        active_voices_in = 8'b0000_0111;
        run_frame(-1, 1'b0);
        total++; if (cap_mix[12] !== 16'sd187) $display("FAIL n3_mix got=%0d exp=187", cap_mix[12]); else passed++;
        // Two voices: 100 - 301 = -201, >>> 1 -> -101 (floor).
        addr_in[0] = 8'd20; addr_in[7] = 8'd21;
        mem[20] = 16'sd100; mem[21] = -16'sd301;
        active_voices_in = 8'b1000_0001;
        run_frame(-1, 1'b0);
        total++; if (v_en !== 17'h00102) $display("FAIL n2_en got=%h exp=00102", v_en); else passed++;
        total++; if (cap_mix[12] !== -16'sd101) $display("FAIL n2_mix got=%0d exp=-101", cap_mix[12]); else passed++;
        // One voice: unscaled.
        addr_in[4] = 8'd50;
        mem[50] = -16'sd7;
        active_voices_in = 8'b0001_0000;
        run_frame(-1, 1'b0);
        total++; if (v_en !== 17'h00020) $display("FAIL n1_en got=%h exp=00020", v_en); else passed++;
        total++; if (cap_mix[12] !== -16'sd7) $display("FAIL n1_mix got=%0d exp=-7", cap_mix[12]); else passed++;
    endtask

    task automatic test_overrun();
        fill(16'sd1200);
        active_voices_in = 8'hFF;
        run_frame(5, 1'b0);
        total++; if (v_ovr !== 17'h00040) $display("FAIL ovr_mid got=%h exp=00040", v_ovr); else passed++;
        total++; if (cap_mix[12] !== 16'sd1200) $display("FAIL ovr_mid_mix got=%0d exp=1200", cap_mix[12]); else passed++;
        total++; if (v_busy !== BUSY_EXP) $display("FAIL ovr_mid_busy got=%h exp=%h", v_busy, BUSY_EXP); else passed++;
        total++; if (v_valid !== VALID_EXP) $display("FAIL ovr_mid_valid got=%h exp=%h", v_valid, VALID_EXP); else passed++;
        // Tick in the output cycle is still an overrun and starts nothing.
        run_frame(12, 1'b0);
        total++; if (v_ovr !== 17'h02000) $display("FAIL ovr_out got=%h exp=02000", v_ovr); else passed++;
        total++; if (v_en !== 17'h001FE) $display("FAIL ovr_out_en got=%h exp=001fe", v_en); else passed++;
        total++; if (v_busy !== BUSY_EXP) $display("FAIL ovr_out_busy got=%h exp=%h", v_busy, BUSY_EXP); else passed++;
    endtask

    task automatic test_reset_midframe();
        int valid_seen;
        fill(16'sd900);
        active_voices_in = 8'hFF;
        step();
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        for (int k = 2; k <= 6; k++) step();
        rst_in = 1'b0;
        #1;
        total++; if ({rd_en_out, busy_out, mix_valid_out, overrun_out} !== 4'b0000)
            $display("FAIL rstmid_flags got=%b exp=0000", {rd_en_out, busy_out, mix_valid_out, overrun_out}); else passed++;
        total++; if (mix_out !== 16'sd0) $display("FAIL rstmid_mix got=%0d exp=0", mix_out); else passed++;
        total++; if (rd_addr_out !== 8'd0) $display("FAIL rstmid_addr got=%0d exp=0", rd_addr_out); else passed++;
        step();
        step();
        rst_in = 1'b1;
        valid_seen = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if (mix_valid_out || busy_out) valid_seen++;
        end
        total++; if (valid_seen !== 0) $display("FAIL rstmid_aborted got=%0d exp=0", valid_seen); else passed++;
        fill(16'sd2000);
        run_frame(-1, 1'b0);
        total++; if (v_valid !== VALID_EXP) $display("FAIL rstmid_new_valid got=%h exp=%h", v_valid, VALID_EXP); else passed++;
        total++; if (cap_mix[12] !== 16'sd2000) $display("FAIL rstmid_new_mix got=%0d exp=2000", cap_mix[12]); else passed++;
    endtask

    initial begin
        fill(16'sd0);
        test_reset();
        test_all_active();
        test_sparse_snapshot();
        test_no_voices();
        test_full_negative();
        test_scaling();
        test_overrun();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of each wavetable address.
REQ-002 Parameter SAMPLE_WIDTH, default 16, signed two's-complement wavetable sample width.
REQ-003 Parameter RD_LATENCY, default 2, fixed wavetable read latency in cycles (1..4).
REQ-004 clk_in  input  1  sole clock, all state on rising edge.
REQ-005 rst_in  input  1  asynchronous, active-low reset.
REQ-006 addr_in  input  [ADDR_WIDTH-1:0] x8  per-voice wavetable address from address_generator.
REQ-007 active_voices_in  input  8  per-voice active mask from address_generator.
REQ-008 sample_tick_in  input  1  one-cycle pulse at audio sample rate, starts one mix frame.
REQ-009 rd_addr_out  output  ADDR_WIDTH  wavetable read address.
REQ-010 rd_en_out  output  1  wavetable read strobe.
REQ-011 rd_data_in  input  SAMPLE_WIDTH  signed read data, valid RD_LATENCY cycles after rd_en_out.
REQ-012 mix_out  output  SAMPLE_WIDTH  signed normalized mix, held between frames.
REQ-013 mix_valid_out  output  1  one-cycle pulse when mix_out updates.
REQ-014 busy_out  output  1  high while a frame is in progress.
REQ-015 overrun_out  output  1  one-cycle pulse when a tick arrives while busy.

Function
REQ-016 FSM states: IDLE, ISSUE, DRAIN, NORM, OUT.
REQ-017 IDLE + sample_tick_in at cycle T: snapshot all 8 addr_in and active_voices_in, clear accumulator, go ISSUE; busy_out high from T+1.
REQ-018 ISSUE lasts exactly 8 cycles; at cycle T+1+i, rd_addr_out = snapshot addr[i], rd_en_out = snapshot active[i].
REQ-019 Inactive voices: rd_en_out low, rd_addr_out 0, nothing accumulated.
REQ-020 A delay line of depth RD_LATENCY carries each rd_en_out; rd_data_in is sign-extended and added to accumulator only when the delayed flag is high.
REQ-021 Accumulator width SAMPLE_WIDTH+3; never overflows.
REQ-022 DRAIN lasts RD_LATENCY cycles after ISSUE, then NORM for 1 cycle, then OUT for 1 cycle, then IDLE.
REQ-023 NORM: n = popcount of snapshot mask; shift = 0 for n<=1, 1 for n=2, 2 for n=3..4, 3 for n=5..8; mix = accumulator arithmetic-shifted right by shift, truncated to SAMPLE_WIDTH (always fits).
REQ-024 n=0: mix_out = 0, still produces mix_valid_out at normal time.
REQ-025 OUT: mix_out registered, mix_valid_out high exactly at cycle T+10+RD_LATENCY (T+12 at default); busy_out low from the following cycle.
REQ-026 Fixed latency regardless of mask contents.
REQ-027 sample_tick_in while busy_out high (including the OUT cycle): ignored, overrun_out pulses next cycle, frame in progress unaffected.
REQ-028 Input changes after snapshot have no effect on the current frame.
REQ-029 mix_out holds last value until next mix_valid_out.

Reset
REQ-030 rst_in low asynchronously forces: state IDLE, mix_out 0, mix_valid_out 0, busy_out 0, overrun_out 0, rd_en_out 0, rd_addr_out 0, accumulator, snapshot and delay line cleared.
REQ-031 Reset mid-frame aborts the frame; no mix_valid_out for it; first tick after release starts a fresh frame.

Structure
REQ-032 Shared package synth_pkg holds NUM_VOICES=8, SAMPLE_WIDTH default, and the FSM state enum.
REQ-033 One sub-module, rd_valid_pipe: RD_LATENCY-deep 1-bit shift register with async active-low reset.

Verification
REQ-034 All 8 voices active, wavetable model returns 1000 for every address -> sum 8000, shift 3, mix_out=1000, mix_valid_out at T+12.
REQ-035 Mask 8'b0000_0101, addr[0]=3 returns 32767, addr[2]=9 returns 32767 -> rd_en_out only at T+1 and T+3 with addresses 3 and 9, mix_out=32767.
REQ-036 Mask 0 -> no rd_en_out pulses, mix_out=0, mix_valid_out at T+12.
REQ-037 All 8 active returning -32768 -> mix_out=-32768, no wrap.
REQ-038 Second tick at T+5 -> overrun_out at T+6, first frame result unchanged at T+12, no second frame.
REQ-039 rst_in low at T+6 -> all outputs 0 immediately, no mix_valid_out; new tick after release yields correct mix at +12.
